// File: rtl/vga_text_renderer_if.sv
// rtl/vga_text_renderer_if.sv - character-RAM and font-ROM read bus for the text renderer
interface vga_text_renderer_if;
   logic [13:0] char_addr_o;
   logic [7:0]  char_data_i;
   logic [11:0] font_addr_o;
   logic [7:0]  font_data_i;

   modport master (
      output char_addr_o,
      output font_addr_o,
      input  char_data_i,
      input  font_data_i
   );

   modport slave (
      input  char_addr_o,
      input  font_addr_o,
      output char_data_i,
      output font_data_i
   );
endinterface

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 3-stage 8x16 text-mode pixel renderer with sync delay
// Optional blinking underline cursor enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_renderer #(
   parameter int          COLS     = 160,
   parameter int          ROWS     = 64,
   parameter logic [11:0] FG_COLOR = 12'hFFF,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       hsync_i,
   input  logic                       vsync_i,
   input  logic                       activevideo_i,
   input  logic [10:0]                x_px_i,
   input  logic [10:0]                y_px_i,
   vga_text_renderer_if.master        mem,
   input  logic [7:0]                 cursor_col_i,
   input  logic [5:0]                 cursor_row_i,
   output logic [3:0]                 red_o,
   output logic [3:0]                 green_o,
   output logic [3:0]                 blue_o,
   output logic                       hsync_o,
   output logic                       vsync_o
);

   localparam logic [8:0]  COLS_W  = 9'(COLS);
   localparam logic [7:0]  ROWS_W  = 8'(ROWS);
   localparam logic [13:0] COLS_14 = 14'(COLS);

   logic [7:0]  col;
   logic [6:0]  row;
   logic [2:0]  gx;
   logic [3:0]  gy;
   logic        in_range;
   logic        pix_bit;
   logic        cur_vis;

   // Stage 1
   logic [13:0] char_addr_d, char_addr_q;
   logic [2:0]  gx1_d, gx1_q;
   logic [3:0]  gy1_d, gy1_q;
   logic        act1_d, act1_q;
   logic        inr1_d, inr1_q;
   logic        hs1_d, hs1_q;
   logic        vs1_d, vs1_q;

   // Stage 2
   logic [11:0] font_addr_d, font_addr_q;
   logic [2:0]  gx2_d, gx2_q;
   logic        act2_d, act2_q;
   logic        inr2_d, inr2_q;
   logic        hs2_d, hs2_q;
   logic        vs2_d, vs2_q;

   // Stage 3
   logic [11:0] rgb_d, rgb_q;
   logic        hs3_d, hs3_q;
   logic        vs3_d, vs3_q;

`ifdef VGA_TEXT_CURSOR_EN
   logic        cur1_d, cur1_q;
   logic        cur2_d, cur2_q;
   logic [4:0]  blink_d, blink_q;
   logic        vs_prev_d, vs_prev_q;
`else
   logic        unused_cursor;
   assign unused_cursor = ^{cursor_col_i, cursor_row_i};
`endif

   always_comb begin
      col      = x_px_i[10:3];
      row      = y_px_i[10:4];
      gx       = x_px_i[2:0];
      gy       = y_px_i[3:0];
      in_range = activevideo_i && ({1'b0, col} < COLS_W) && ({1'b0, row} < ROWS_W);

      // Out-of-grid pixels still issue a (truncated) read; the colour stage masks them.
      char_addr_d = {7'b0, row} * COLS_14 + {6'b0, col};
      gx1_d       = gx;
      gy1_d       = gy;
      act1_d      = activevideo_i;
      inr1_d      = in_range;
      hs1_d       = hsync_i;
      vs1_d       = vsync_i;

      font_addr_d = {mem.char_data_i, gy1_q};
      gx2_d       = gx1_q;
      act2_d      = act1_q;
      inr2_d      = inr1_q;
      hs2_d       = hs1_q;
      vs2_d       = vs1_q;

      // Bit 7 is the leftmost pixel, so the bit index is the inverted glyph column.
      pix_bit = mem.font_data_i[~gx2_q];

`ifdef VGA_TEXT_CURSOR_EN
      cur1_d    = in_range && (col == cursor_col_i) && (row == {1'b0, cursor_row_i})
                  && (gy >= 4'd14);
      cur2_d    = cur1_q;
      vs_prev_d = vsync_i;
      blink_d   = blink_q;
      if (vs_prev_q && !vsync_i) begin
         blink_d = blink_q + 5'd1;
      end
      cur_vis   = cur2_q && !blink_q[4];
`else
      cur_vis   = 1'b0;
`endif

      if (!act2_q) begin
         rgb_d = 12'h000;
      end else if (!inr2_q) begin
         rgb_d = BG_COLOR;
      end else if (pix_bit || cur_vis) begin
         rgb_d = FG_COLOR;
      end else begin
         rgb_d = BG_COLOR;
      end
      hs3_d = hs2_q;
      vs3_d = vs2_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         char_addr_q <= '0;
         gx1_q       <= '0;
         gy1_q       <= '0;
         act1_q      <= 1'b0;
         inr1_q      <= 1'b0;
         hs1_q       <= 1'b1;
         vs1_q       <= 1'b1;
         font_addr_q <= '0;
         gx2_q       <= '0;
         act2_q      <= 1'b0;
         inr2_q      <= 1'b0;
         hs2_q       <= 1'b1;
         vs2_q       <= 1'b1;
         rgb_q       <= '0;
         hs3_q       <= 1'b1;
         vs3_q       <= 1'b1;
      end else begin
         char_addr_q <= char_addr_d;
         gx1_q       <= gx1_d;
         gy1_q       <= gy1_d;
         act1_q      <= act1_d;
         inr1_q      <= inr1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         font_addr_q <= font_addr_d;
         gx2_q       <= gx2_d;
         act2_q      <= act2_d;
         inr2_q      <= inr2_d;
         hs2_q       <= hs2_d;
         vs2_q       <= vs2_d;
         rgb_q       <= rgb_d;
         hs3_q       <= hs3_d;
         vs3_q       <= vs3_d;
      end
   end

`ifdef VGA_TEXT_CURSOR_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur1_q    <= 1'b0;
         cur2_q    <= 1'b0;
         blink_q   <= '0;
         vs_prev_q <= 1'b1;
      end else begin
         cur1_q    <= cur1_d;
         cur2_q    <= cur2_d;
         blink_q   <= blink_d;
         vs_prev_q <= vs_prev_d;
      end
   end
`endif

   assign mem.char_addr_o = char_addr_q;
   assign mem.font_addr_o = font_addr_q;
   assign red_o           = rgb_q[11:8];
   assign green_o         = rgb_q[7:4];
   assign blue_o          = rgb_q[3:0];
   assign hsync_o         = hs3_q;
   assign vsync_o         = vs3_q;

endmodule
